// File: rtl/decim_ctrl_pkg.sv
// Shared types and constants for the receive-side decimation controller.
// Samples are two's-complement; the accumulator carries 3 guard bits for up to 8 samples.
package decim_ctrl_pkg;

    localparam int SAMPLE_W  = 14;
    localparam int ACC_GUARD = 3;
    localparam int ACC_W     = SAMPLE_W + ACC_GUARD;
    localparam int NUM_LANES = 2;

    localparam logic [1:0] RATIO_1 = 2'd0;
    localparam logic [1:0] RATIO_2 = 2'd1;
    localparam logic [1:0] RATIO_4 = 2'd2;
    localparam logic [1:0] RATIO_8 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_RUN       = 2'd2
    } state_e;

    // Phase value at which a group of N samples completes (N-1).
    function automatic logic [2:0] ratio_last_phase(input logic [1:0] r);
        logic [2:0] last;
        case (r)
            RATIO_1: last = 3'd0;
            RATIO_2: last = 3'd1;
            RATIO_4: last = 3'd3;
            default: last = 3'd7;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/decim_ctrl_acc.sv
// Dual-lane (I/Q) group accumulator with a floor-divide-by-N output register.
// The ratio code doubles as log2(N), so it is used directly as the shift amount.
module decim_acc
    import decim_ctrl_pkg::*;
#(
    parameter int W  = SAMPLE_W,
    parameter int AW = W + ACC_GUARD
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        flush_i,
    input  logic                        restart_i,
    input  logic                        add_i,
    input  logic                        emit_i,
    input  logic [1:0]                  shift_i,
    input  logic                        out_clr_i,
    input  logic [NUM_LANES-1:0][W-1:0] smp_i,
    output logic [NUM_LANES-1:0][W-1:0] res_o
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic signed [AW-1:0] acc_q;
        logic signed [AW-1:0] acc_d;
        logic signed [AW-1:0] sum;
        logic        [W-1:0]  res_q;

        // restart drops the partial group so the current sample starts a fresh one.
        always_comb begin
            sum   = (restart_i ? '0 : acc_q) + {{(AW-W){smp_i[g][W-1]}}, smp_i[g]};
            acc_d = acc_q;
            if (flush_i) begin
                acc_d = '0;
            end else if (add_i) begin
                acc_d = emit_i ? '0 : sum;
            end else if (restart_i) begin
                acc_d = '0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                acc_q <= '0;
                res_q <= '0;
            end else begin
                acc_q <= acc_d;
                if (out_clr_i) begin
                    res_q <= '0;
                end else if (emit_i) begin
                    res_q <= W'(sum >>> shift_i);
                end
            end
        end

        assign res_o[g] = res_q;
    end

endmodule

// File: rtl/decim_ctrl.sv
// Phase-controlled I/Q decimator: sync aligns group phase and symbol index,
// then one averaged sample per N inputs is emitted with sop/cp markers.
module decim_ctrl
    import decim_ctrl_pkg::*;
#(
    parameter int W       = SAMPLE_W,
    parameter int SYM_LEN = 80,
    parameter int CP_LEN  = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         enable_i,
    input  logic [1:0]   ratio_i,
    input  logic         sync_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_I_i,
    input  logic [W-1:0] in_Q_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_I_o,
    output logic [W-1:0] out_Q_o,
    output logic         sop_o,
    output logic         cp_o,
    output logic [7:0]   sym_cnt_o,
    output logic         locked_o
);

    localparam int IDX_W = $clog2(SYM_LEN);

    state_e                     state_q;
    logic [1:0]                 ratio_q;
    logic [2:0]                 phase_q;
    logic [IDX_W-1:0]           idx_q;
    logic [7:0]                 sym_q;
    logic                       out_valid_q;
    logic                       sop_q;
    logic                       cp_q;
    logic                       locked_q;

    logic                       run;
    logic                       old_complete;
    logic                       realign;
    logic                       sync_late;
    logic                       complete;
    logic                       idx_last;
    logic [1:0]                 ratio_eff;
    logic [2:0]                 phase_eff;
    logic [IDX_W-1:0]           idx_eff;
    logic [7:0]                 sym_eff;
    logic [NUM_LANES-1:0][W-1:0] acc_res;

    // A sync that lands on a completing sample lets that group finish under the old
    // ratio and realigns afterwards; otherwise it realigns before this sample is used.
    always_comb begin
        run          = (state_q == ST_RUN);
        old_complete = in_valid_i && (phase_q == ratio_last_phase(ratio_q));
        realign      = run && enable_i && sync_i && !old_complete;
        sync_late    = run && enable_i && sync_i && old_complete;
        ratio_eff    = realign ? ratio_i : ratio_q;
        phase_eff    = realign ? 3'd0 : phase_q;
        idx_eff      = realign ? '0 : idx_q;
        sym_eff      = realign ? 8'd0 : sym_q;
        complete     = run && in_valid_i && (phase_eff == ratio_last_phase(ratio_eff));
        idx_last     = (idx_eff == IDX_W'(SYM_LEN - 1));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            ratio_q     <= RATIO_1;
            phase_q     <= '0;
            idx_q       <= '0;
            sym_q       <= '0;
            out_valid_q <= 1'b0;
            sop_q       <= 1'b0;
            cp_q        <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            sop_q       <= 1'b0;
            cp_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sym_q    <= '0;
                    locked_q <= 1'b0;
                    if (enable_i) begin
                        state_q <= ST_WAIT_SYNC;
                    end
                end
                ST_WAIT_SYNC: begin
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                    end else if (sync_i) begin
                        state_q  <= ST_RUN;
                        locked_q <= 1'b1;
                        ratio_q  <= ratio_i;
                        phase_q  <= '0;
                        idx_q    <= '0;
                        sym_q    <= '0;
                    end
                end
                ST_RUN: begin
                    ratio_q <= ratio_eff;
                    idx_q   <= idx_eff;
                    sym_q   <= sym_eff;
                    if (complete) begin
                        phase_q <= '0;
                    end else if (in_valid_i) begin
                        phase_q <= phase_eff + 3'd1;
                    end else begin
                        phase_q <= phase_eff;
                    end
                    if (complete) begin
                        out_valid_q <= 1'b1;
                        sop_q       <= (idx_eff == '0);
                        cp_q        <= (idx_eff < IDX_W'(CP_LEN));
                        idx_q       <= idx_last ? '0 : idx_eff + 1'b1;
                        if (idx_last) begin
                            sym_q <= sym_eff + 8'd1;
                        end
                    end
                    if (sync_late) begin
                        ratio_q <= ratio_i;
                        idx_q   <= '0;
                        sym_q   <= '0;
                    end
                    if (!enable_i) begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    decim_acc #(.W(W)) u_acc (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .flush_i   (!run),
        .restart_i (realign),
        .add_i     (run && in_valid_i),
        .emit_i    (complete),
        .shift_i   (ratio_eff),
        .out_clr_i (state_q == ST_IDLE),
        .smp_i     ({in_Q_i, in_I_i}),
        .res_o     (acc_res)
    );

    assign out_valid_o = out_valid_q;
    assign out_I_o     = acc_res[0];
    assign out_Q_o     = acc_res[1];
    assign sop_o       = sop_q;
    assign cp_o        = cp_q;
    assign sym_cnt_o   = sym_q;
    assign locked_o    = locked_q;

endmodule
